adc_stream_packer: RTL
======================

ADC_STREAM_PACKER -- requirements
Module: adc_stream_packer

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the drop_cnt_o and pkt_cnt_o counters.
REQ-002 SHALL have port adc_clk_i  in  1  the only clock; all logic on its rising edge.
REQ-003 SHALL have port adc_rstn_i  in  1  reset; asynchronous, active-low.
REQ-004 SHALL have port en_i  in  1  run enable (level); high = capture, falling = flush.
REQ-005 SHALL have port pkt_words_i  in  32  words per packet; values 0 and 1 are treated as 2.
REQ-006 SHALL have port smp_valid_i  in  1  sample strobe.
REQ-007 SHALL have port smp_data_i  in  16  sample value.
REQ-008 SHALL have port m_axis_tdata_o  out  64  packed stream data.
REQ-009 SHALL have port m_axis_tvalid_o  out  1  AXI-Stream valid.
REQ-010 SHALL have port m_axis_tready_i  in  1  AXI-Stream ready from the downstream FIFO.
REQ-011 SHALL have port m_axis_tlast_o  out  1  last word of packet.
REQ-012 SHALL have port m_axis_tkeep_o  out  8  byte qualifiers.
REQ-013 SHALL have port drop_cnt_o  out  CNT_W  words lost to backpressure; saturating.
REQ-014 SHALL have port pkt_cnt_o  out  CNT_W  packets delivered; wrapping.
REQ-015 SHALL have port busy_o  out  1  high whenever the state is not IDLE.

Function
REQ-016 SHALL implement a state machine with states IDLE, RUN and FLUSH.
- IDLE->RUN: en_i=1.
- RUN->FLUSH: en_i=0.
- FLUSH->IDLE: terminator pushed (or none needed) and output buffer empty.
REQ-017 SHALL, on IDLE->RUN, latch the packet length from pkt_words_i, clear lane index and word index, and clear drop_cnt_o.
REQ-018 SHALL accept a sample only when state=RUN, en_i=1 and smp_valid_i=1; samples in IDLE or FLUSH are ignored.
REQ-019 SHALL pack accepted samples little-endian: 1st sample to bits [15:0], 2nd to [31:16], 3rd to [47:32], 4th to [63:48].
REQ-020 SHALL, on the 4th accepted sample, form a word with tkeep=8'hFF and push it into a 2-entry output buffer.
REQ-021 SHALL set tlast on the pushed word when word index = latched length-1, then reset word index to 0 and re-latch pkt_words_i for the next packet.
REQ-022 SHALL, when a word completes while the buffer is full, drop that word, increment drop_cnt_o (saturating at all-ones), leave word index unchanged, and restart the lane index at 0.
REQ-023 SHALL present a word pushed at edge N with tvalid=1 after edge N when the buffer was empty (1-cycle latency).
REQ-024 SHALL hold tdata, tkeep and tlast stable while tvalid=1 and tready=0.
REQ-025 SHALL support a push and a pop in the same cycle with a full buffer without a drop (pop frees the slot first).
REQ-026 SHALL, on entering FLUSH with lane>0, emit the partial word zero-padded, with tkeep=1 for the valid bytes only (2 bytes per sample) and tlast=1.
REQ-027 SHALL, on entering FLUSH with lane=0 and word index>0, emit a terminator word with tdata=0, tkeep=8'h00 and tlast=1.
REQ-028 SHALL emit nothing in FLUSH when lane=0 and word index=0.
REQ-029 SHALL wait in FLUSH for buffer space before pushing the flush word; it is never dropped.
REQ-030 SHALL ignore an en_i rising edge during FLUSH until IDLE is reached.
REQ-031 SHALL increment pkt_cnt_o on every handshake (tvalid&tready) with tlast=1.

Reset
REQ-032 SHALL, while adc_rstn_i=0, force state IDLE, buffer empty, lane and word index 0, and all outputs to 0 (tkeep=8'h00).
REQ-033 SHALL, on reset assertion mid-packet, discard all pending data immediately, with no tlast emitted.

Verification
REQ-034 SHALL be checked with: pkt_words_i=4, tready=1, 16 samples 0..15 -> 4 words; word0=64'h0003_0002_0001_0000; tlast only on word3; pkt_cnt_o=1.
REQ-035 SHALL be checked with: pkt_words_i=0 -> packets of 2 words; tlast on every 2nd word.
REQ-036 SHALL be checked with: tready=0, 12 samples -> 2 words buffered, 3rd dropped; drop_cnt_o=1; buffered data intact after tready=1.
REQ-037 SHALL be checked with: en_i falls after 6 samples (pkt=4) -> word1 carries samples 4,5, tkeep=8'h0F, tlast=1; then IDLE, busy_o=0.
REQ-038 SHALL be checked with: en_i falls after exactly 8 samples (pkt=4) -> terminator word, tkeep=8'h00, tlast=1; pkt_cnt_o=1.
REQ-039 SHALL be checked with: adc_rstn_i pulsed low mid-packet with tready=0 -> tvalid=0 asynchronously; after release, a new run starts at lane 0.

Source files
------------

// File: rtl/adc_stream_packer.sv
// Packs 16-bit ADC samples four-per-word into a 64-bit AXI-Stream with packet framing.
// A 2-entry output buffer absorbs short stalls; words completing into a full buffer are dropped and counted.
module adc_stream_packer #(
    parameter int CNT_W = 32
) (
    input  logic             adc_clk_i,
    input  logic             adc_rstn_i,
    input  logic             en_i,
    input  logic [31:0]      pkt_words_i,
    input  logic             smp_valid_i,
    input  logic [15:0]      smp_data_i,
    output logic [63:0]      m_axis_tdata_o,
    output logic             m_axis_tvalid_o,
    input  logic             m_axis_tready_i,
    output logic             m_axis_tlast_o,
    output logic [7:0]       m_axis_tkeep_o,
    output logic [CNT_W-1:0] drop_cnt_o,
    output logic [CNT_W-1:0] pkt_cnt_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t      state_q, state_d;
    logic [1:0]  lane_q;
    logic [31:0] word_idx_q;
    logic [31:0] pkt_len_q;
    logic [47:0] acc_p0;
    logic [63:0] buf_data [2];
    logic [7:0]  buf_keep [2];
    logic        buf_last [2];
    logic        wr_ptr_q, rd_ptr_q;
    logic [1:0]  cnt_q;

    logic        pop, has_space, accept, word_done, last_word, flush_need;
    logic        push, drop;
    logic [63:0] push_data, part_data;
    logic [7:0]  push_keep, part_keep;
    logic        push_last;

    function automatic logic [31:0] eff_len(input logic [31:0] w);
        return (w < 32'd2) ? 32'd2 : w;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    assign pop        = (cnt_q != 2'd0) && m_axis_tready_i;
    assign has_space  = (cnt_q != 2'd2) || pop;
    assign accept     = (state_q == RUN) && en_i && smp_valid_i;
    assign word_done  = accept && (lane_q == 2'd3);
    assign last_word  = (word_idx_q == pkt_len_q - 32'd1);
    assign flush_need = (lane_q != 2'd0) || (word_idx_q != 32'd0);

    // Partial word for flush; with no samples pending this is the empty terminator.
    always_comb begin
        part_data = '0;
        part_keep = '0;
        for (int i = 0; i < 3; i++) begin
            if (2'(i) < lane_q) begin
                part_data[16*i +: 16] = acc_p0[16*i +: 16];
                part_keep[2*i +: 2]   = 2'b11;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        push      = 1'b0;
        drop      = 1'b0;
        push_data = {smp_data_i, acc_p0};
        push_keep = 8'hFF;
        push_last = last_word;
        case (state_q)
            IDLE: if (en_i) state_d = RUN;
            RUN: begin
                if (!en_i) begin
                    state_d = FLUSH;
                end else if (word_done) begin
                    push = has_space;
                    drop = !has_space;
                end
            end
            FLUSH: begin
                if (flush_need) begin
                    push      = has_space;
                    push_data = part_data;
                    push_keep = part_keep;
                    push_last = 1'b1;
                end else if (cnt_q == 2'd0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            state_q    <= IDLE;
            lane_q     <= 2'd0;
            word_idx_q <= 32'd0;
            pkt_len_q  <= 32'd2;
            drop_cnt_o <= '0;
            pkt_cnt_o  <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            cnt_q      <= 2'd0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && en_i) begin
                pkt_len_q  <= eff_len(pkt_words_i);
                lane_q     <= 2'd0;
                word_idx_q <= 32'd0;
                drop_cnt_o <= '0;
            end else if (state_q == RUN) begin
                if (word_done) begin
                    lane_q <= 2'd0;
                    if (push) begin
                        if (last_word) begin
                            word_idx_q <= 32'd0;
                            pkt_len_q  <= eff_len(pkt_words_i);
                        end else begin
                            word_idx_q <= word_idx_q + 32'd1;
                        end
                    end else if (drop) begin
                        drop_cnt_o <= sat_inc(drop_cnt_o);
                    end
                end else if (accept) begin
                    lane_q <= lane_q + 2'd1;
                end
            end else if (state_q == FLUSH && push) begin
                lane_q     <= 2'd0;
                word_idx_q <= 32'd0;
            end

            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
            if (pop && buf_last[rd_ptr_q]) pkt_cnt_o <= pkt_cnt_o + CNT_ONE;
        end
    end

    // Datapath storage: sample accumulator and buffer slots, qualified by the control above.
    always_ff @(posedge adc_clk_i) begin
        if (accept) begin
            case (lane_q)
                2'd0:    acc_p0[15:0]  <= smp_data_i;
                2'd1:    acc_p0[31:16] <= smp_data_i;
                2'd2:    acc_p0[47:32] <= smp_data_i;
                default: acc_p0        <= acc_p0;
            endcase
        end
        if (push) begin
            buf_data[wr_ptr_q] <= push_data;
            buf_keep[wr_ptr_q] <= push_keep;
            buf_last[wr_ptr_q] <= push_last;
        end
    end

    assign m_axis_tvalid_o = (cnt_q != 2'd0);
    assign m_axis_tdata_o  = m_axis_tvalid_o ? buf_data[rd_ptr_q] : 64'd0;
    assign m_axis_tkeep_o  = m_axis_tvalid_o ? buf_keep[rd_ptr_q] : 8'h00;
    assign m_axis_tlast_o  = m_axis_tvalid_o && buf_last[rd_ptr_q];
    assign busy_o          = (state_q != IDLE);

endmodule
